// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared RAM map, frame states and NCO increment helper for the BPSK receiver
package bpsk_pkg;

  localparam logic [31:0] RAM1_BASEADDR        = 32'h0000_0100;
  localparam logic [31:0] RAM2_BASEADDR        = 32'h0000_0200;
  localparam logic [31:0] EMPTY_FRAME_BASEADDR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_SYNC_WORD    = 32'h1ACF_FC1D;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_CHECK = 2'd2
  } frame_state_t;

  // Rounded increment so a 32-bit accumulator wraps once per symbol.
  function automatic logic [31:0] nco_inc(input longint unsigned baud, input longint unsigned fclk);
    longint unsigned num;
    num = (baud << 32) + (fclk >> 1);
    return 32'(num / fclk);
  endfunction

endpackage

// File: rtl/bpsk_rx_bit_sync.sv
// rtl/bpsk_rx_bit_sync.sv - phase synchroniser, baud NCO and differential decoder
module bpsk_rx_bit_sync #(
  parameter logic [31:0] INC = 32'd322123
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phase_in,
  output logic bit_tick,
  output logic rx_bit
);

  logic        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [31:0] acc_q, acc_d;
  logic        phase_prev_q, phase_prev_d;
  logic        bit_tick_q, bit_tick_d;
  logic        rx_bit_q, rx_bit_d;
  logic [32:0] sum;

  always_comb begin
    sync1_d = phase_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    sum = {1'b0, acc_q} + {1'b0, INC};
    // An edge recentres the NCO half a symbol out; a tick in that same clk still counts.
    acc_d = (sync2_q ^ sync3_q) ? 32'h8000_0000 : sum[31:0];
    bit_tick_d = sum[32];
    phase_prev_d = sum[32] ? sync2_q : phase_prev_q;
    rx_bit_d = sum[32] ? (sync2_q ^ phase_prev_q) : rx_bit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      acc_q        <= 32'h0;
      phase_prev_q <= 1'b0;
      bit_tick_q   <= 1'b0;
      rx_bit_q     <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      acc_q        <= acc_d;
      phase_prev_q <= phase_prev_d;
      bit_tick_q   <= bit_tick_d;
      rx_bit_q     <= rx_bit_d;
    end
  end

  assign bit_tick = bit_tick_q;
  assign rx_bit   = rx_bit_q;

endmodule

// File: rtl/bpsk_rx_deframer.sv
// rtl/bpsk_rx_deframer.sv - BPSK receive deframer: sync hunt, word packing, ping-pong RAM frame writes
// Define BPSK_RX_FLYWHEEL_EN to re-check the sync word word-aligned after each frame instead of hunting.
module bpsk_rx_deframer
  import bpsk_pkg::*;
#(
  parameter int unsigned data_width   = 32,
  parameter int unsigned frame_length = 38,
  parameter int unsigned addr_width   = 32,
  parameter int unsigned ref_clk_freq = 128000000,
  parameter int unsigned baudrate     = 9600,
  parameter logic [31:0] SYNC_WORD    = DEFAULT_SYNC_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  power_on,
  input  logic                  phase_in,
  output logic                  ram_clk,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_wr_data,
  output logic                  ram_rst,
  output logic [1:0]            interrupt_num,
  output logic                  sync_lock
);

  localparam logic [31:0]       INC      = nco_inc(64'(baudrate), 64'(ref_clk_freq));
  localparam int unsigned       IDX_W    = $clog2(frame_length);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(frame_length - 1);

  logic bit_tick, rx_bit;

  bpsk_rx_bit_sync #(.INC(INC)) u_bit_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase_in (phase_in),
    .bit_tick (bit_tick),
    .rx_bit   (rx_bit)
  );

  frame_state_t          state_q, state_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic                  buf_sel_q, buf_sel_d;
  logic                  ram_en_q, ram_en_d;
  logic [addr_width-1:0] ram_addr_q, ram_addr_d;
  logic [data_width-1:0] ram_wr_data_q, ram_wr_data_d;
  logic [1:0]            irq_pend_q, irq_pend_d;
  logic [1:0]            irq_q, irq_d;
  logic                  sync_lock_q, sync_lock_d;
  logic [31:0]           base, wr_addr;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    buf_sel_d     = buf_sel_q;
    ram_en_d      = 1'b0;
    ram_addr_d    = addr_width'(EMPTY_FRAME_BASEADDR);
    ram_wr_data_d = '0;
    irq_pend_d    = 2'b00;
    irq_d         = irq_pend_q;
    base          = buf_sel_q ? RAM2_BASEADDR : RAM1_BASEADDR;
    wr_addr       = base + (32'(word_idx_q) << 2);

    if (bit_tick) shreg_d = {shreg_q[30:0], rx_bit};

    if (!power_on) begin
      state_d    = ST_HUNT;
      bit_cnt_d  = 5'd0;
      word_idx_d = '0;
    end else if (bit_tick) begin
      case (state_q)
        ST_HUNT: begin
          if (shreg_d == SYNC_WORD) begin
            state_d       = ST_LOCK;
            word_idx_d    = IDX_W'(1);
            bit_cnt_d     = 5'd0;
            ram_en_d      = 1'b1;
            ram_addr_d    = addr_width'(base);
            ram_wr_data_d = data_width'(SYNC_WORD);
          end
        end
        ST_LOCK: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            ram_en_d      = 1'b1;
            ram_addr_d    = addr_width'(wr_addr);
            ram_wr_data_d = data_width'(shreg_d);
            word_idx_d    = word_idx_q + IDX_W'(1);
            if (word_idx_q == LAST_IDX) begin
              // Interrupt names the buffer just filled; the pointer moves on now.
              irq_pend_d = buf_sel_q ? 2'b10 : 2'b01;
              buf_sel_d  = ~buf_sel_q;
              word_idx_d = '0;
`ifdef BPSK_RX_FLYWHEEL_EN
              state_d    = ST_CHECK;
`else
              state_d    = ST_HUNT;
`endif
            end
          end
        end
`ifdef BPSK_RX_FLYWHEEL_EN
        ST_CHECK: begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            if (shreg_d == SYNC_WORD) begin
              state_d       = ST_LOCK;
              word_idx_d    = IDX_W'(1);
              ram_en_d      = 1'b1;
              ram_addr_d    = addr_width'(base);
              ram_wr_data_d = data_width'(SYNC_WORD);
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
`endif
        default: state_d = ST_HUNT;
      endcase
    end

    sync_lock_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      shreg_q       <= 32'h0;
      bit_cnt_q     <= 5'd0;
      word_idx_q    <= '0;
      buf_sel_q     <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      irq_pend_q    <= 2'b00;
      irq_q         <= 2'b00;
      sync_lock_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      buf_sel_q     <= buf_sel_d;
      ram_en_q      <= ram_en_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      irq_pend_q    <= irq_pend_d;
      irq_q         <= irq_d;
      sync_lock_q   <= sync_lock_d;
    end
  end

  assign ram_clk       = clk;
  assign ram_rst       = 1'b0;
  assign ram_en        = ram_en_q;
  assign ram_we        = {4{ram_en_q}};
  assign ram_addr      = ram_addr_q;
  assign ram_wr_data   = ram_wr_data_q;
  assign interrupt_num = irq_q;
  assign sync_lock     = sync_lock_q;

endmodule
